// File: rtl/ssd_scroll_ctrl.sv
// ssd_scroll_ctrl
//   Scrolling-text driver for a multiplexed common-anode 7-segment display.
//   Holds MSG_LEN 4-bit character codes, scans DIGITS digits one slot at a
//   time, and rotates the message left or right at a programmable rate.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   msg          character codes, char i = msg[4i+3:4i]
//   en           1 = scrolling runs, 0 = hold current offset and scroll count
//   dir          0 = scroll left (offset+1), 1 = scroll right (offset-1)
//   load         one-cycle pulse: offset and scroll count back to 0
//   blank        1 = all digits off
//   ssd_ctl      digit enables, active-low, bit DIGITS-1 = leftmost digit
//   ssd_seg      segments {a,b,c,d,e,f,g,dp}, active-low
//   scroll_tick  one-cycle pulse when the offset steps
module ssd_scroll_ctrl #(
  parameter int DIGITS     = 4,
  parameter int MSG_LEN    = 5,
  parameter int SCAN_DIV   = 100000,
  parameter int SCROLL_DIV = 50000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4*MSG_LEN-1:0]   msg,
  input  logic                   en,
  input  logic                   dir,
  input  logic                   load,
  input  logic                   blank,
  output logic [DIGITS-1:0]      ssd_ctl,
  output logic [7:0]             ssd_seg,
  output logic                   scroll_tick
);

  localparam int SCAN_W   = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
  localparam int SCROLL_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int DIG_W    = (DIGITS     > 1) ? $clog2(DIGITS)     : 1;
  localparam int OFF_W    = (MSG_LEN    > 1) ? $clog2(MSG_LEN)    : 1;
  // offset + (k mod MSG_LEN) is at most 2*MSG_LEN-2, one extra bit holds it.
  localparam int SUM_W    = OFF_W + 1;

  localparam logic [SCAN_W-1:0]   SCAN_LAST   = SCAN_W'(SCAN_DIV - 1);
  localparam logic [SCROLL_W-1:0] SCROLL_LAST = SCROLL_W'(SCROLL_DIV - 1);
  localparam logic [DIG_W-1:0]    DIG_LAST    = DIG_W'(DIGITS - 1);
  localparam logic [OFF_W-1:0]    MSG_LAST    = OFF_W'(MSG_LEN - 1);
  localparam logic [SUM_W-1:0]    MSG_LEN_S   = SUM_W'(MSG_LEN);

  logic [SCAN_W-1:0]   scan_cnt_q,   scan_cnt_d;
  logic [DIG_W-1:0]    digit_q,      digit_d;
  logic [OFF_W-1:0]    kmod_q,       kmod_d;      // digit index mod MSG_LEN
  logic [SCROLL_W-1:0] scroll_cnt_q, scroll_cnt_d;
  logic [OFF_W-1:0]    offset_q,     offset_d;
  logic [DIGITS-1:0]   ctl_q,        ctl_d;
  logic [7:0]          seg_q,        seg_d;
  logic                tick_q,       tick_d;

  logic [SUM_W-1:0]    char_sum;
  logic [SUM_W-1:0]    char_wrap;
  logic [OFF_W-1:0]    char_idx;
  logic [3:0]          char_code;

  function automatic logic [7:0] decode_char(input logic [3:0] code);
    case (code)
      4'd0:    decode_char = 8'b11010101;  // n
      4'd1:    decode_char = 8'b11100001;  // t
      4'd2:    decode_char = 8'b10010001;  // h
      4'd3:    decode_char = 8'b10000011;  // u
      4'd4:    decode_char = 8'b01100001;  // e
      default: decode_char = 8'b11111111;  // blank
    endcase
  endfunction

  // Digit scan: free-running, independent of en, blank and load. kmod
  // tracks digit index mod MSG_LEN so the character index only ever
  // needs a single compare-subtract even when DIGITS > MSG_LEN.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path
    // leaves it unassigned, which would infer a latch.
    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    digit_d    = digit_q;
    kmod_d     = kmod_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      if (digit_q == DIG_LAST) begin
        digit_d = '0;
        kmod_d  = '0;
      end else begin
        digit_d = digit_q + DIG_W'(1);
        kmod_d  = (kmod_q == MSG_LAST) ? '0 : kmod_q + OFF_W'(1);
      end
    end
  end

  // Scroll: load wins over a coincident terminal count and swallows the tick.
  always_comb begin
    scroll_cnt_d = scroll_cnt_q;
    offset_d     = offset_q;
    tick_d       = 1'b0;
    if (load) begin
      scroll_cnt_d = '0;
      offset_d     = '0;
    end else if (en) begin
      if (scroll_cnt_q == SCROLL_LAST) begin
        scroll_cnt_d = '0;
        tick_d       = 1'b1;
        if (!dir) offset_d = (offset_q == MSG_LAST) ? '0 : offset_q + OFF_W'(1);
        else      offset_d = (offset_q == '0) ? MSG_LAST : offset_q - OFF_W'(1);
      end else begin
        scroll_cnt_d = scroll_cnt_q + SCROLL_W'(1);
      end
    end
  end

  // Character for the digit currently being scanned.
  always_comb begin
    char_sum  = {1'b0, offset_q} + {1'b0, kmod_q};
    char_wrap = (char_sum >= MSG_LEN_S) ? char_sum - MSG_LEN_S : char_sum;
    char_idx  = char_wrap[OFF_W-1:0];
    char_code = msg[{char_idx, 2'b00} +: 4];
  end

  // Pin values for the next cycle.
  always_comb begin
    ctl_d = '1;
    seg_d = 8'hFF;
    if (!blank) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (int'(digit_q) == DIGITS - 1 - i) ctl_d[i] = 1'b0;
      end
      seg_d = decode_char(char_code);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q   <= '0;
      digit_q      <= '0;
      kmod_q       <= '0;
      scroll_cnt_q <= '0;
      offset_q     <= '0;
      ctl_q        <= '1;
      seg_q        <= 8'hFF;
      tick_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples the values
      // from before this edge, regardless of statement order.
      scan_cnt_q   <= scan_cnt_d;
      digit_q      <= digit_d;
      kmod_q       <= kmod_d;
      scroll_cnt_q <= scroll_cnt_d;
      offset_q     <= offset_d;
      ctl_q        <= ctl_d;
      seg_q        <= seg_d;
      tick_q       <= tick_d;
    end
  end

  assign ssd_ctl     = ctl_q;
  assign ssd_seg     = seg_q;
  assign scroll_tick = tick_q;

endmodule

// File: tb/tb_ssd_scroll_ctrl.sv
// Directed testbench for ssd_scroll_ctrl with DIGITS=4, MSG_LEN=5,
// SCAN_DIV=2, SCROLL_DIV=8. Inputs change and outputs are sampled 1 ns
// after the rising edge. Cycle numbers in comments count rising edges
// since the final reset release; the digit visible after edge c is
// ((c-1)/2) mod 4.
module tb_ssd_scroll_ctrl;

  localparam logic [7:0] SEG_N   = 8'b11010101;
  localparam logic [7:0] SEG_T   = 8'b11100001;
  localparam logic [7:0] SEG_H   = 8'b10010001;
  localparam logic [7:0] SEG_U   = 8'b10000011;
  localparam logic [7:0] SEG_E   = 8'b01100001;
  localparam logic [7:0] SEG_OFF = 8'b11111111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] msg;
  logic        en, dir, load, blank;
  logic [3:0]  ssd_ctl;
  logic [7:0]  ssd_seg;
  logic        scroll_tick;

  int n_tests = 0;
  int n_fail  = 0;

  ssd_scroll_ctrl #(
    .DIGITS     (4),
    .MSG_LEN    (5),
    .SCAN_DIV   (2),
    .SCROLL_DIV (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .msg         (msg),
    .en          (en),
    .dir         (dir),
    .load        (load),
    .blank       (blank),
    .ssd_ctl     (ssd_ctl),
    .ssd_seg     (ssd_seg),
    .scroll_tick (scroll_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_pins(input string tag, input logic [3:0] ctl, input logic [7:0] seg);
    check({tag, "_ctl"}, 8'(ssd_ctl), 8'(ctl));
    check({tag, "_seg"}, ssd_seg, seg);
  endtask

  // Steps until scroll_tick is seen (bounded) and checks how many cycles it took.
  task automatic wait_tick(input string tag, input int exp_n);
    int n;
    n = 0;
    do begin
      step(1);
      n++;
    end while (scroll_tick !== 1'b1 && n < 20);
    check({tag, "_seen"}, 8'(scroll_tick), 8'd1);
    check({tag, "_cycles"}, 8'(n), 8'(exp_n));
  endtask

  initial begin
    rst_n = 1'b0;
    msg   = 20'h43210;
    en    = 1'b0;
    dir   = 1'b0;
    load  = 1'b0;
    blank = 1'b0;

    step(2);
    check_pins("por", 4'b1111, SEG_OFF);
    check("por_tick", 8'(scroll_tick), 8'd0);

    // Run with scrolling so the counters are mid-count, then reset between edges.
    rst_n = 1'b1;
    en    = 1'b1;
    step(11);
    #3 rst_n = 1'b0;
    #1;
    check_pins("rst_async", 4'b1111, SEG_OFF);
    check("rst_async_tick", 8'(scroll_tick), 8'd0);
    en = 1'b0;
    step(2);
    check_pins("rst_held", 4'b1111, SEG_OFF);
    rst_n = 1'b1;

    // Scan with en=0, offset 0.
    step(1);  // c=1
    check_pins("scan_d0", 4'b0111, SEG_N);
    step(1);  // c=2
    check_pins("scan_d0_hold", 4'b0111, SEG_N);
    step(1);  // c=3
    check_pins("scan_d1", 4'b1011, SEG_T);
    step(2);  // c=5
    check_pins("scan_d2", 4'b1101, SEG_H);
    step(2);  // c=7
    check_pins("scan_d3", 4'b1110, SEG_U);
    check("scan_no_tick", 8'(scroll_tick), 8'd0);

    // Left scroll: ticks at c=15,23,31,39,47; leftmost visible two cycles later.
    en = 1'b1;
    wait_tick("left1", 8);
    step(1);
    check("left1_pulse", 8'(scroll_tick), 8'd0);
    step(1);
    check_pins("left1", 4'b0111, SEG_T);
    wait_tick("left2", 6);
    step(2);
    check_pins("left2", 4'b0111, SEG_H);
    wait_tick("left3", 6);
    step(2);
    check_pins("left3", 4'b0111, SEG_U);
    wait_tick("left4", 6);
    step(2);
    check_pins("left4", 4'b0111, SEG_E);
    wait_tick("left5", 6);
    step(2);  // c=49
    check_pins("left5_wrap", 4'b0111, SEG_N);

    // Right scroll from offset 0 wraps to 4: tick at c=55.
    dir = 1'b1;
    wait_tick("right1", 6);
    step(1);  // c=56, rightmost digit
    check("right1_pulse", 8'(scroll_tick), 8'd0);
    check_pins("right1_rightmost", 4'b1110, SEG_H);
    step(1);  // c=57, leftmost digit
    check_pins("right1_leftmost", 4'b0111, SEG_E);

    // Hold for 24 cycles: no tick, offset stays 4, scroll count stays 2.
    en = 1'b0;
    for (int i = 0; i < 24; i++) begin
      step(1);
      check("hold_no_tick", 8'(scroll_tick), 8'd0);
    end
    check_pins("hold_offset", 4'b0111, SEG_E);  // c=81

    // Resume: count 2 reaches terminal on edge 87, where load also hits.
    en = 1'b1;
    step(5);  // c=86
    load = 1'b1;
    step(1);  // c=87
    load = 1'b0;
    check("load_no_tick", 8'(scroll_tick), 8'd0);
    step(2);  // c=89
    check_pins("load_offset0", 4'b0111, SEG_N);
    dir = 1'b0;
    wait_tick("after_load", 6);  // tick at c=95, 8 cycles after the load edge
    step(2);  // c=97
    check_pins("after_load_left", 4'b0111, SEG_T);

    // Blank while holding, with a load back to offset 0.
    en    = 1'b0;
    load  = 1'b1;
    blank = 1'b1;
    step(1);  // c=98
    load = 1'b0;
    check_pins("blank1", 4'b1111, SEG_OFF);
    check("blank_no_tick", 8'(scroll_tick), 8'd0);
    step(2);  // c=100
    check_pins("blank2", 4'b1111, SEG_OFF);

    // Unblank with char 0 replaced by an undefined code; scan kept going.
    blank = 1'b0;
    msg   = 20'h43219;
    step(1);  // c=101, digit 2
    check_pins("unblank_d2", 4'b1101, SEG_H);
    step(4);  // c=105, digit 0
    check_pins("code9_d0", 4'b0111, SEG_OFF);
    step(2);  // c=107, digit 1
    check_pins("code9_d1", 4'b1011, SEG_T);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ssd_scroll_ctrl.md
Name: ssd_scroll_ctrl

Overview:
- Parametrised multi-digit 7-segment scrolling-text driver.
- Holds a message of MSG_LEN character codes and time-multiplexes DIGITS common-anode digits.
- Rotates the message left or right at a programmable rate, with hold, reload and blank controls.
- Sits between the top-level control FSM and the board SSD pins, and replaces per-digit combinational letter decoders.

Parameters:
DIGITS, 4, number of physical digits scanned (>=1)
MSG_LEN, 5, number of characters in the message (>=1)
SCAN_DIV, 100000, clk cycles per digit slot (>=1)
SCROLL_DIV, 50000000, clk cycles per scroll step while enabled (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
msg  input  4*MSG_LEN  character codes; char i = msg[4i+3:4i]
en  input  1  1 = scrolling runs; 0 = hold current offset
dir  input  1  0 = scroll left (offset+1); 1 = scroll right (offset-1)
load  input  1  one-cycle pulse: restart message at offset 0
blank  input  1  1 = all digits off
ssd_ctl  output  DIGITS  digit enables, active-low; bit DIGITS-1 = leftmost digit
ssd_seg  output  8  segments {a,b,c,d,e,f,g,dp}, active-low
scroll_tick  output  1  one-cycle pulse when offset changes

Behaviour:
- Single clock domain. Reset is asynchronous and active-low on rst_n.
- Reset state:
  - scan counter = 0, digit index = 0, scroll counter = 0, offset = 0
  - ssd_ctl = all ones, ssd_seg = 8'b11111111, scroll_tick = 0
- Character decode (combinational, internal):
  - 0 -> 11010101 (n), 1 -> 11100001 (t), 2 -> 10010001 (h), 3 -> 10000011 (u), 4 -> 01100001 (e)
  - codes 5..15 -> 11111111 (blank)
- Scan:
  - Scan counter counts 0..SCAN_DIV-1 and wraps.
  - On terminal count, digit index advances 0..DIGITS-1 and wraps to 0.
  - Scan runs regardless of en and blank.
- Digit mapping:
  - Digit index k drives the k-th digit from the left, i.e. ssd_ctl bit DIGITS-1-k.
  - That digit shows char (offset+k) mod MSG_LEN.
- Output registration:
  - ssd_ctl and ssd_seg are registered every cycle from the current digit index, offset, msg and blank.
  - Latency is 1 clk from any of those changing to the pins.
  - Exactly one ssd_ctl bit is low when blank=0. All bits are high when blank=1; ssd_seg is then 11111111.
- Scroll:
  - When en=1, the scroll counter counts 0..SCROLL_DIV-1. On terminal count it wraps to 0, steps the offset, and asserts scroll_tick for that one cycle (registered, concurrent with the offset update).
  - dir=0: offset MSG_LEN-1 -> 0 wrap.
  - dir=1: offset 0 -> MSG_LEN-1 wrap.
  - MSG_LEN=1: offset stays 0, but scroll_tick still pulses.
  - When en=0, the scroll counter and offset hold. Re-enabling resumes from the held count.
- load:
  - Forces offset = 0 and scroll counter = 0, and suppresses scroll_tick that cycle.
  - Has priority over a coincident terminal count.
  - Does not affect scan state.
- dir change takes effect on the next step; no extra step is generated.
- MSG_LEN < DIGITS: characters repeat modulo MSG_LEN across the digits.
- Modulo arithmetic must be correct for non-power-of-2 MSG_LEN and DIGITS. Implement it with a compare-subtract on a clog2-sized sum, not truncation.
- Reset mid-operation: all state returns to reset values immediately. Operation resumes on the first clk edge after rst_n rises.

Test Plan:
- Bench setup: DIGITS=4, MSG_LEN=5, SCAN_DIV=2, SCROLL_DIV=8, msg chars 0..4 = codes 0,1,2,3,4.
- Reset: rst_n=0 mid-count -> ssd_ctl=4'b1111, ssd_seg=11111111, scroll_tick=0 immediately. After release with en=0 -> ssd_ctl cycles 0111,1011,1101,1110, each held 2 clk; segs 11010101, 11100001, 10010001, 10000011.
- Left scroll: en=1, dir=0 -> scroll_tick every 8 clk. After 1 tick the leftmost digit shows 11100001. After 5 ticks offset wraps to 0 and the leftmost digit shows 11010101.
- Right scroll with wrap: en=1, dir=1 from offset 0 -> after 1 tick the leftmost digit shows 01100001 (char 4) and the rightmost shows 10010001 (char 2).
- Hold and load: en=0 for 20 clk -> no scroll_tick, offset unchanged. Then load coincident with scroll terminal count -> offset=0, no scroll_tick, next tick 8 clk later.
- Blank and default codes: blank=1 -> ssd_ctl=1111 within 1 clk while scan continues. blank=0 with msg char 0 = code 9 -> that digit shows 11111111.
